// File: rtl/reg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_scan_pkg
// Brief    : Shared types and constants for the register file scanner.
//            Macro REG_SCAN_SKIP_ZERO_EN selects 1 as the first scanned index
//            (index 0 is then never visited).
// Revision : 1.0 - initial release
// ============================================================================
package reg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LOAD  = 2'd2,
        HOLD  = 2'd3
    } scan_state_t;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DWELL    = 25_000_000;

`ifdef REG_SCAN_SKIP_ZERO_EN
    // Index 0 is hard-wired to zero in the register file, so it can be skipped.
    localparam int FIRST_IDX = 1;
`else
    localparam int FIRST_IDX = 0;
`endif

endpackage
`default_nettype wire

// File: rtl/step_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : step_edge_sync
// Brief    : Two-flop synchroniser for a raw board switch plus a one-cycle
//            rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module step_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync_d;

    // Bring the asynchronous switch into the clk domain and keep one delayed copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= din;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    // Combinational pulse so the FSM reacts on the third edge after the rise.
    assign rise = sync2 & ~sync_d;

endmodule
`default_nettype wire

// File: rtl/reg_file_scanner.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scanner
// Brief    : Walks the register file one index at a time through its second
//            read port and captures each word for the board display.
//            Auto mode dwells DWELL cycles per register; manual mode advances
//            on a step switch rising edge.
//            Macro REG_SCAN_SKIP_ZERO_EN: scan indices 1..NUM_REGS-1 only.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_scanner
    import reg_scan_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int IDX_W    = 5,
    parameter int DATA_W   = 32,
    parameter int DWELL    = DEF_DWELL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_en,
    input  logic              step_mode,
    input  logic              step,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  disp_idx,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap
);

    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [IDX_W-1:0] FIRST    = IDX_W'(FIRST_IDX);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [CNT_W-1:0] cnt;
    logic             step_pulse;
    logic             advance;

    step_edge_sync u_step_sync (
        .clk   (clk),
        .reset (reset),
        .din   (step),
        .rise  (step_pulse)
    );

    assign idx_next = (idx == LAST) ? FIRST : idx + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and advance decision; dropping scan_en parks from any state.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        if (!scan_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = ISSUE;
                ISSUE:   state_next = LOAD;
                LOAD:    state_next = HOLD;
                HOLD: begin
                    // Step pulses outside HOLD are simply never looked at.
                    advance = step_mode ? step_pulse : (cnt == CNT_LAST);
                    if (advance) begin
                        state_next = ISSUE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Dwell counter: runs only in auto-mode HOLD, otherwise held at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (scan_en && (state == HOLD) && !step_mode && (cnt != CNT_LAST)) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Index, read address and wrap pulse move together on an advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= FIRST;
            rd_addr <= FIRST;
            wrap    <= 1'b0;
        end else begin
            wrap <= advance && (idx == LAST);
            if (advance) begin
                idx     <= idx_next;
                rd_addr <= idx_next;
            end
        end
    end

    // Capture the returned word at the end of LOAD; valid drops with scan_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_idx   <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else if (!scan_en) begin
            disp_valid <= 1'b0;
        end else if (state == LOAD) begin
            disp_idx   <= idx;
            disp_data  <= rd_data;
            disp_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_scanner
// Brief    : Self-checking bench for reg_file_scanner with DWELL = 4 and a
//            randomly filled register file model behind a registered read port.
//            Honours REG_SCAN_SKIP_ZERO_EN when the RTL is built with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_scanner;

    localparam int NR    = 32;
    localparam int IW    = 5;
    localparam int DW    = 32;
    localparam int DWELL = 4;
`ifdef REG_SCAN_SKIP_ZERO_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          scan_en   = 1'b0;
    logic          step_mode = 1'b0;
    logic          step      = 1'b0;
    logic [IW-1:0] rd_addr;
    logic [DW-1:0] rd_data   = '0;
    logic [IW-1:0] disp_idx;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          wrap;

    logic [DW-1:0] regs [NR];
    int            tests = 0;
    int            fails = 0;
    int            cur;
    int            laps;
    int            nwait;

    reg_file_scanner #(
        .NUM_REGS (NR),
        .IDX_W    (IW),
        .DATA_W   (DW),
        .DWELL    (DWELL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_en    (scan_en),
        .step_mode  (step_mode),
        .step       (step),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .disp_idx   (disp_idx),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Register file read port: address sampled on an edge, data out after it.
    always @(posedge clk) rd_data <= regs[rd_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int nxt(input int i);
        return (i == NR - 1) ? FIRST : i + 1;
    endfunction

    task automatic chk_disp(input string tag, input int i);
        chk({tag, "_idx"}, 64'(disp_idx), 64'(i));
        chk({tag, "_data"}, 64'(disp_data), 64'(regs[i]));
    endtask

    initial begin
        for (int i = 0; i < NR; i++) regs[i] = (i == 0) ? '0 : DW'($urandom);

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #1;
        chk("rst_rd_addr", 64'(rd_addr), 64'(FIRST));
        chk("rst_disp_idx", 64'(disp_idx), 0);
        chk("rst_disp_data", 64'(disp_data), 0);
        chk("rst_disp_valid", 64'(disp_valid), 0);
        chk("rst_wrap", 64'(wrap), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            cyc();
            chk("parked_valid", 64'(disp_valid), 0);
        end

        // Auto scan: first capture three edges after enable, then every DWELL+2.
        scan_en = 1'b1;
        cyc(); chk("start_valid1", 64'(disp_valid), 0);
        cyc(); chk("start_valid2", 64'(disp_valid), 0);
        cyc(); chk("start_valid3", 64'(disp_valid), 1);
        chk_disp("first", FIRST);
        cur  = FIRST;
        laps = 0;
        for (int n = 0; n < 100 && !(laps == 1 && cur == 7); n++) begin
            for (int k = 1; k <= DWELL + 2; k++) begin
                cyc();
                if (k < DWELL + 2) chk_disp("auto_hold", cur);
                else               chk_disp("auto_new", nxt(cur));
                chk("auto_wrap", 64'(wrap), 64'(k == DWELL && cur == NR - 1));
                chk("auto_rd_addr", 64'(rd_addr), 64'((k >= DWELL) ? nxt(cur) : cur));
                chk("auto_valid", 64'(disp_valid), 1);
            end
            if (cur == NR - 1) laps++;
            cur = nxt(cur);
        end
        chk("reach_idx7", 64'(cur), 7);

        // Enable drop while index 7 is held, then resume at the retained index.
        cyc();
        scan_en = 1'b0;
        cyc();
        chk("drop_valid", 64'(disp_valid), 0);
        chk_disp("drop_keep", 7);
        chk("drop_rd_addr", 64'(rd_addr), 7);
        nwait = int'($urandom_range(1, 5));
        for (int i = 0; i < nwait; i++) begin
            cyc();
            chk("parked2_valid", 64'(disp_valid), 0);
        end
        scan_en = 1'b1;
        cyc(); chk("resume_valid1", 64'(disp_valid), 0);
        cyc(); chk("resume_valid2", 64'(disp_valid), 0);
        cyc(); chk("resume_valid3", 64'(disp_valid), 1);
        chk_disp("resume", 7);

        // Manual mode: no movement without a step.
        step_mode = 1'b1;
        nwait = int'($urandom_range(100, 120));
        for (int i = 0; i < nwait; i++) begin
            cyc();
            chk_disp("man_still", 7);
            chk("man_rd_addr", 64'(rd_addr), 7);
        end
        // One-cycle step rise, then a second rise timed to land in LOAD.
        step = 1'b1; cyc();
        step = 1'b0; cyc();
        step = 1'b1; cyc();
        chk("man_issue_addr", 64'(rd_addr), 8);
        chk_disp("man_edge3", 7);
        step = 1'b0; cyc();
        chk_disp("man_edge4", 7);
        cyc();
        chk_disp("man_edge5", 8);
        for (int i = 0; i < 30; i++) begin
            cyc();
            chk_disp("man_load_ignored", 8);
            chk("man_load_rd_addr", 64'(rd_addr), 8);
        end

        // Back to auto: dwell restarts from zero.
        step_mode = 1'b0;
        for (int k = 1; k <= DWELL + 2; k++) begin
            cyc();
            chk_disp("reauto", (k < DWELL + 2) ? 8 : 9);
            chk("reauto_rd_addr", 64'(rd_addr), 64'((k >= DWELL) ? 9 : 8));
        end

        // Reset mid-HOLD takes effect without a clock edge.
        cyc();
        reset = 1'b0;
        #1;
        chk("midrst_rd_addr", 64'(rd_addr), 64'(FIRST));
        chk("midrst_disp_idx", 64'(disp_idx), 0);
        chk("midrst_disp_data", 64'(disp_data), 0);
        chk("midrst_disp_valid", 64'(disp_valid), 0);
        chk("midrst_wrap", 64'(wrap), 0);
        cyc();
        chk("midrst_hold_valid", 64'(disp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
